// File: rtl/shiftreg_burst_if.sv
// Handshake/data bundle for shiftreg_burst.
// Master drives op/d/amt/Lin/Rin; slave returns q/sout/busy/done.
interface shiftreg_burst_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N) + 1;

  logic [2:0]    op;
  logic [N-1:0]  d;
  logic [CW-1:0] amt;
  logic          Lin;
  logic          Rin;
  logic [N-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  modport master (
    output op, d, amt, Lin, Rin,
    input  q, sout, busy, done
  );

  modport slave (
    input  op, d, amt, Lin, Rin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shiftreg_burst.sv
// Universal shift register with burst shifts and busy/done handshake.
// Define SHIFTREG_ROTATE_EN to enable rotate bursts (ops 110/111).
module shiftreg_burst #(
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst_n,
  shiftreg_burst_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [N-1:0]  q, q_n;
  logic          sout, sout_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done, done_n;
  logic          dir, dir_n;
  logic          fill_r, fill_l;
  logic          burst;

`ifdef SHIFTREG_ROTATE_EN
  logic rot, rot_n;
  assign burst  = bus.op[2];
  assign fill_r = rot ? q[0]   : bus.Lin;
  assign fill_l = rot ? q[N-1] : bus.Rin;
`else
  assign burst  = bus.op[2] & ~bus.op[1];
  assign fill_r = bus.Lin;
  assign fill_l = bus.Rin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      sout  <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      dir   <= 1'b0;
`ifdef SHIFTREG_ROTATE_EN
      rot   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      q     <= q_n;
      sout  <= sout_n;
      cnt   <= cnt_n;
      done  <= done_n;
      dir   <= dir_n;
`ifdef SHIFTREG_ROTATE_EN
      rot   <= rot_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    sout_n  = sout;
    cnt_n   = cnt;
    done_n  = 1'b0;
    dir_n   = dir;
`ifdef SHIFTREG_ROTATE_EN
    rot_n   = rot;
`endif
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          bus.op == 3'b001: begin
            q_n    = {bus.Lin, q[N-1:1]};
            sout_n = q[0];
          end
          bus.op == 3'b010: begin
            q_n    = {q[N-2:0], bus.Rin};
            sout_n = q[N-1];
          end
          bus.op == 3'b011: q_n = bus.d;
          burst: begin
            dir_n = bus.op[0];
`ifdef SHIFTREG_ROTATE_EN
            rot_n = bus.op[1];
`endif
            // zero-length burst completes at once
            if (bus.amt == '0) begin
              done_n = 1'b1;
            end else begin
              cnt_n   = bus.amt;
              state_n = RUN;
            end
          end
          default: ;
        endcase
      end
      RUN: begin
        if (dir) begin
          q_n    = {q[N-2:0], fill_l};
          sout_n = q[N-1];
        end else begin
          q_n    = {fill_r, q[N-1:1]};
          sout_n = q[0];
        end
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.q    = q;
  assign bus.sout = sout;
  assign bus.busy = (state == RUN);
  assign bus.done = done;
endmodule

// File: tb/tb_shiftreg_burst.sv
// Directed scoreboard bench for shiftreg_burst (N=8).
// Expectations follow SHIFTREG_ROTATE_EN when it is defined.
module tb_shiftreg_burst;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  shiftreg_burst_if #(.N(8)) bus ();

  shiftreg_burst #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;

`ifdef SHIFTREG_ROTATE_EN
  localparam logic S4 = 1'b1;
`else
  localparam logic S4 = 1'b0;
`endif

  logic [7:0] des_q[8] = '{8'h80, 8'h40, 8'hA0, 8'hD0,
                           8'h68, 8'h34, 8'h9A, 8'h4D};
  logic       des_b[8] = '{1'b1, 1'b0, 1'b1, 1'b1,
                           1'b0, 1'b0, 1'b1, 1'b0};

  task automatic push(input logic [7:0] q, input logic s,
                      input logic b, input logic dn,
                      input string t);
    exp_t e;
    e.q = q; e.sout = s; e.busy = b; e.done = dn; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic cmp(input string t, input logic [7:0] got,
                     input logic [7:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", t, got, exp);
  endtask

  task automatic chk();
    exp_t e;
    nchk++;
    assert (sb.size() > 0) npass++;
    else begin
      $error("FAIL scoreboard: got empty expected entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".q"}, bus.q, e.q);
    cmp({e.tag, ".sout"}, {7'd0, bus.sout}, {7'd0, e.sout});
    cmp({e.tag, ".busy"}, {7'd0, bus.busy}, {7'd0, e.busy});
    cmp({e.tag, ".done"}, {7'd0, bus.done}, {7'd0, e.done});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk();
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] d,
                       input logic [3:0] amt);
    bus.op = op; bus.d = d; bus.amt = amt;
  endtask

  initial begin
    bus.op = 3'b000; bus.d = '0; bus.amt = '0;
    bus.Lin = 1'b0; bus.Rin = 1'b0;

    #3;
    push(8'h00, 0, 0, 0, "reset");
    chk();
    #9 rst_n = 1'b1;

    // load, single shift right, hold
    drive(3'b011, 8'hA5, 0);
    push(8'hA5, 0, 0, 0, "load_a5"); tick();
    drive(3'b001, 8'h00, 0); bus.Lin = 1'b1;
    push(8'hD2, 1, 0, 0, "shr1"); tick();
    drive(3'b000, 8'h00, 0); bus.Lin = 1'b0;
    push(8'hD2, 1, 0, 0, "hold"); tick();

    // burst left by 3
    drive(3'b011, 8'h81, 0);
    push(8'h81, 1, 0, 0, "load_81"); tick();
    drive(3'b101, 8'h00, 3); bus.Rin = 1'b0;
    push(8'h81, 1, 1, 0, "bsl_acc"); tick();
    drive(3'b000, 8'h00, 0);
    push(8'h02, 1, 1, 0, "bsl_e1"); tick();
    push(8'h04, 0, 1, 0, "bsl_e2"); tick();
    push(8'h08, 0, 0, 1, "bsl_e3"); tick();
    push(8'h08, 0, 0, 0, "bsl_post"); tick();

    // deserialise with ignored mid-burst load
    drive(3'b011, 8'h00, 0);
    push(8'h00, 0, 0, 0, "load_00"); tick();
    drive(3'b100, 8'h00, 8);
    push(8'h00, 0, 1, 0, "des_acc"); tick();
    drive(3'b000, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      bus.Lin = des_b[i];
      if (i == 3) drive(3'b011, 8'hFF, 0);
      else drive(3'b000, 8'h00, 0);
      push(des_q[i], 0, (i != 7), (i == 7), "des");
      tick();
    end
    drive(3'b000, 8'h00, 0); bus.Lin = 1'b0;
    push(8'h4D, 0, 0, 0, "des_post"); tick();

    // rotate right by 4
    drive(3'b011, 8'h3C, 0);
    push(8'h3C, 0, 0, 0, "load_3c"); tick();
    drive(3'b110, 8'h00, 4);
`ifdef SHIFTREG_ROTATE_EN
    push(8'h3C, 0, 1, 0, "ror_acc"); tick();
    drive(3'b000, 8'h00, 0);
    push(8'h1E, 0, 1, 0, "ror_e1"); tick();
    push(8'h0F, 0, 1, 0, "ror_e2"); tick();
    push(8'h87, 1, 1, 0, "ror_e3"); tick();
    push(8'hC3, 1, 0, 1, "ror_e4"); tick();
`else
    push(8'h3C, 0, 0, 0, "ror_off0"); tick();
    drive(3'b000, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      push(8'h3C, 0, 0, 0, "ror_off"); tick();
    end
`endif

    // amt=0 burst, then back-to-back burst in done cycle
    drive(3'b011, 8'h5A, 0);
    push(8'h5A, S4, 0, 0, "load_5a"); tick();
    drive(3'b100, 8'h00, 0);
    push(8'h5A, S4, 0, 1, "amt0"); tick();
    drive(3'b101, 8'h00, 1); bus.Rin = 1'b1;
    push(8'h5A, S4, 1, 0, "b2b_acc"); tick();
    drive(3'b000, 8'h00, 0);
    push(8'hB5, 0, 0, 1, "b2b_e1"); tick();
    bus.Rin = 1'b0;
    push(8'hB5, 0, 0, 0, "b2b_post"); tick();

    // reset in the middle of a 5-shift burst
    drive(3'b101, 8'h00, 5);
    push(8'hB5, 0, 1, 0, "rst_acc"); tick();
    drive(3'b000, 8'h00, 0);
    push(8'h6A, 1, 1, 0, "rst_e1"); tick();
    #2 rst_n = 1'b0;
    #1;
    push(8'h00, 0, 0, 0, "rst_mid"); chk();
    #2 rst_n = 1'b1;
    drive(3'b011, 8'h3C, 0);
    push(8'h3C, 0, 0, 0, "rst_load"); tick();
    drive(3'b000, 8'h00, 0);
    push(8'h3C, 0, 0, 0, "rst_hold"); tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
